// File: rtl/alu_pkg.sv
// alu_pkg: opcode encoding and flag bit positions shared by the ALU pipeline
package alu_pkg;
  localparam logic [2:0] OP_ADD  = 3'd0;
  localparam logic [2:0] OP_SUB  = 3'd1;
  localparam logic [2:0] OP_AND  = 3'd2;
  localparam logic [2:0] OP_OR   = 3'd3;
  localparam logic [2:0] OP_XOR  = 3'd4;
  localparam logic [2:0] OP_NOT  = 3'd5;
  localparam logic [2:0] OP_NAND = 3'd6;
  localparam logic [2:0] OP_RSVD = 3'd7;
  localparam int FLG_C = 3;
  localparam int FLG_V = 2;
  localparam int FLG_Z = 1;
  localparam int FLG_N = 0;
endpackage

// File: rtl/alu_pipe_if.sv
// alu_pipe_if: operand-in and result-out handshakes of the pipelined ALU
interface alu_pipe_if #(parameter int WIDTH = 8);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [2:0]       sel;
  logic             acc_en;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out;
  logic [3:0]       flags;
  logic [WIDTH-1:0] acc;
  modport master (
    output in_valid, a, b, sel, acc_en, out_ready,
    input  in_ready, out_valid, out, flags, acc
  );
  modport slave (
    input  in_valid, a, b, sel, acc_en, out_ready,
    output in_ready, out_valid, out, flags, acc
  );
endinterface

// File: rtl/alu_core.sv
// alu_core: combinational ALU producing result and {carry, overflow, zero, negative}
module alu_core
  import alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       sel,
  output logic [WIDTH-1:0] res,
  output logic [3:0]       flags
);
  logic [WIDTH:0] sum;
  logic [WIDTH:0] diff;
  assign sum  = {1'b0, a} + {1'b0, b};
  assign diff = {1'b0, a} - {1'b0, b};
  // result mux plus flags; the extra top bit of diff is the unsigned borrow
  always_comb begin
    res = sel == OP_ADD  ? sum[WIDTH-1:0]  :
          sel == OP_SUB  ? diff[WIDTH-1:0] :
          sel == OP_AND  ? a & b           :
          sel == OP_OR   ? a | b           :
          sel == OP_XOR  ? a ^ b           :
          sel == OP_NOT  ? ~a              :
          sel == OP_NAND ? ~(a & b)        : '0;
    flags = '0;
    flags[FLG_C] = sel == OP_ADD ? sum[WIDTH] : (sel == OP_SUB) && diff[WIDTH];
    flags[FLG_V] = ((sel == OP_ADD && a[WIDTH-1] == b[WIDTH-1]) ||
                    (sel == OP_SUB && a[WIDTH-1] != b[WIDTH-1])) && (res[WIDTH-1] != a[WIDTH-1]);
    flags[FLG_Z] = res == '0;
    flags[FLG_N] = res[WIDTH-1];
  end
endmodule

// File: rtl/alu_pipe.sv
// alu_pipe: two-stage valid/ready ALU with status flags and accumulator chaining
module alu_pipe
  import alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input logic       clk,
  input logic       rst,
  alu_pipe_if.slave bus
);
  logic             s1_valid;
  logic             s1_acc_en;
  logic [2:0]       s1_sel;
  logic [WIDTH-1:0] s1_a;
  logic [WIDTH-1:0] s1_b;
  logic             s1_adv;
  logic             s2_valid;
  logic [WIDTH-1:0] out_q;
  logic [3:0]       flags_q;
  logic [WIDTH-1:0] acc_q;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] res;
  logic [3:0]       flg;
  assign s1_adv        = s1_valid && (!s2_valid || bus.out_ready);
  assign bus.in_ready  = !rst && (!s1_valid || s1_adv);
  assign bus.out_valid = s2_valid;
  assign bus.out       = out_q;
  assign bus.flags     = flags_q;
  assign bus.acc       = acc_q;
  assign op_a          = s1_acc_en ? acc_q : s1_a;
  alu_core #(.WIDTH(WIDTH)) u_core (
    .a     (op_a),
    .b     (s1_b),
    .sel   (s1_sel),
    .res   (res),
    .flags (flg)
  );
  // s1 captures an accepted op and empties when it moves on to s2
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      s1_valid  <= 1'b0;
      s1_acc_en <= 1'b0;
      s1_sel    <= '0;
      s1_a      <= '0;
      s1_b      <= '0;
    end else if (bus.in_valid && bus.in_ready) begin
      s1_valid  <= 1'b1;
      s1_acc_en <= bus.acc_en;
      s1_sel    <= bus.sel;
      s1_a      <= bus.a;
      s1_b      <= bus.b;
    end else if (s1_adv) begin
      s1_valid <= 1'b0;
    end
  // s2 registers result and flags; acc tracks every result so chained ops see the previous one
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      s2_valid <= 1'b0;
      out_q    <= '0;
      flags_q  <= '0;
      acc_q    <= '0;
    end else if (s1_adv) begin
      s2_valid <= 1'b1;
      out_q    <= res;
      flags_q  <= flg;
      acc_q    <= res;
    end else if (bus.out_ready) begin
      s2_valid <= 1'b0;
    end
endmodule

// File: tb/tb_alu_pipe.sv
// tb_alu_pipe: directed and randomized checks of alu_pipe against an arithmetic model
module tb_alu_pipe;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  alu_pipe_if #(.WIDTH(8))  bus8 ();
  alu_pipe_if #(.WIDTH(16)) bus16 ();
  alu_pipe #(.WIDTH(8))  u8  (.clk(clk), .rst(rst), .bus(bus8));
  alu_pipe #(.WIDTH(16)) u16 (.clk(clk), .rst(rst), .bus(bus16));

  int n_cmp = 0;
  int n_bad = 0;
  int unsigned macc = 0;
  logic [19:0] q[$];

  function automatic int sgn(int x, int w);
    return x >= (1 << (w - 1)) ? x - (1 << w) : x;
  endfunction

  // returns {carry, overflow, zero, negative, result[15:0]} from plain integer arithmetic
  function automatic logic [19:0] model(int w, int a, int b, int sel);
    int m, r, s;
    logic c, v;
    m = 1 << w;
    c = 1'b0;
    v = 1'b0;
    r = 0;
    case (sel)
      0: begin r = (a + b) % m; c = (a + b) >= m; s = sgn(a, w) + sgn(b, w); v = s >= m / 2 || s < -(m / 2); end
      1: begin r = (a + m - b) % m; c = a < b; s = sgn(a, w) - sgn(b, w); v = s >= m / 2 || s < -(m / 2); end
      2: r = a & b;
      3: r = a | b;
      4: r = a ^ b;
      5: r = (m - 1) - a;
      6: r = (m - 1) - (a & b);
      default: r = 0;
    endcase
    return {c, v, r == 0, r >= m / 2, 16'(r)};
  endfunction

  // model for the 8-bit unit; the accumulator is simply the last result produced
  function automatic logic [19:0] exp8(logic [7:0] a, logic [7:0] b, logic [2:0] sel, logic en);
    logic [19:0] e;
    e = model(8, en ? int'(macc) : int'({24'b0, a}), int'({24'b0, b}), int'({29'b0, sel}));
    macc = {16'b0, e[15:0]};
    return e;
  endfunction

  task automatic drive8(logic v, logic [7:0] a, logic [7:0] b, logic [2:0] sel, logic en);
    bus8.in_valid = v;
    bus8.a = a;
    bus8.b = b;
    bus8.sel = sel;
    bus8.acc_en = en;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive8(0, 0, 0, 0, 0);
    bus8.out_ready = 1'b1;
    bus16.in_valid = 1'b0;
    bus16.a = '0;
    bus16.b = '0;
    bus16.sel = '0;
    bus16.acc_en = 1'b0;
    bus16.out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++;
    if ({bus8.out_valid, bus8.out, bus8.flags, bus8.acc} !== 21'b0) begin
      n_bad++;
      $display("FAIL reset_state8: got v=%0b out=%h f=%b acc=%h want all 0", bus8.out_valid, bus8.out, bus8.flags, bus8.acc);
    end
    n_cmp++;
    if ({bus16.out_valid, bus16.out, bus16.flags, bus16.acc} !== 37'b0) begin
      n_bad++;
      $display("FAIL reset_state16: got v=%0b out=%h f=%b acc=%h want all 0", bus16.out_valid, bus16.out, bus16.flags, bus16.acc);
    end
    rst = 1'b0;
    macc = 0;
    #1;
    n_cmp++;
    if (bus8.in_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL reset_in_ready: got %b want 1", bus8.in_ready);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_opcodes();
    logic [7:0] want[8];
    logic [19:0] e[8];
    want = '{8'h08, 8'h02, 8'h01, 8'h07, 8'h06, 8'hFA, 8'hFE, 8'h00};
    for (int i = 0; i < 8; i++) e[i] = exp8(8'h05, 8'h03, 3'(i), 1'b0);
    bus8.out_ready = 1'b1;
    drive8(1, 8'h05, 8'h03, 3'd0, 0);
    for (int j = 0; j < 10; j++) begin
      @(posedge clk);
      #1;
      n_cmp++;
      if (j >= 1 && j <= 8) begin
        if ({bus8.out_valid, bus8.out, bus8.flags, bus8.acc} !== {1'b1, want[j-1], e[j-1][19:16], want[j-1]}) begin
          n_bad++;
          $display("FAIL opcode_sel%0d: got v=%0b out=%h f=%b acc=%h want v=1 out=%h f=%b", j - 1,
                   bus8.out_valid, bus8.out, bus8.flags, bus8.acc, want[j-1], e[j-1][19:16]);
        end
        n_cmp++;
        if ({bus8.flags[1], bus8.flags[0]} !== {j == 8, want[j-1][7]}) begin
          n_bad++;
          $display("FAIL opcode_zn_sel%0d: got z=%b n=%b want z=%b n=%b", j - 1, bus8.flags[1], bus8.flags[0], j == 8, want[j-1][7]);
        end
      end else if (bus8.out_valid !== 1'b0) begin
        n_bad++;
        $display("FAIL opcode_latency_cycle%0d: got out_valid=%b want 0", j, bus8.out_valid);
      end
      if (j < 7) drive8(1, 8'h05, 8'h03, 3'(j + 1), 0);
      else drive8(0, 0, 0, 0, 0);
    end
  endtask

  task automatic test_flag_bounds();
    logic [7:0] ta[4], tb[4], wr[4];
    logic [2:0] ts[4];
    logic [3:0] wf[4];
    logic [19:0] e[4];
    ta = '{8'hFF, 8'h7F, 8'h03, 8'h80};
    tb = '{8'h01, 8'h01, 8'h05, 8'h01};
    ts = '{3'd0, 3'd0, 3'd1, 3'd1};
    wr = '{8'h00, 8'h80, 8'hFE, 8'h7F};
    wf = '{4'b1010, 4'b0101, 4'b1001, 4'b0100};
    for (int i = 0; i < 4; i++) e[i] = exp8(ta[i], tb[i], ts[i], 1'b0);
    drive8(1, ta[0], tb[0], ts[0], 0);
    for (int j = 0; j < 6; j++) begin
      @(posedge clk);
      #1;
      if (j >= 1 && j <= 4) begin
        n_cmp++;
        if ({bus8.out_valid, bus8.out, bus8.flags} !== {1'b1, wr[j-1], wf[j-1]}) begin
          n_bad++;
          $display("FAIL flag_bound%0d: got v=%0b out=%h f=%b want v=1 out=%h f=%b", j - 1,
                   bus8.out_valid, bus8.out, bus8.flags, wr[j-1], wf[j-1]);
        end
        n_cmp++;
        if (bus8.flags !== e[j-1][19:16]) begin
          n_bad++;
          $display("FAIL flag_model%0d: got f=%b model f=%b", j - 1, bus8.flags, e[j-1][19:16]);
        end
      end
      if (j < 3) drive8(1, ta[j+1], tb[j+1], ts[j+1], 0);
      else drive8(0, 0, 0, 0, 0);
    end
  endtask

  task automatic test_acc_chain();
    logic [7:0] want[4];
    logic [19:0] e;
    want = '{8'h00, 8'h03, 8'h06, 8'h09};
    e = exp8(8'h00, 8'h00, 3'd0, 1'b0);
    drive8(1, 8'h00, 8'h00, 3'd0, 0);
    for (int j = 0; j < 6; j++) begin
      @(posedge clk);
      #1;
      if (j >= 1 && j <= 4) begin
        n_cmp++;
        if ({bus8.out_valid, bus8.out, bus8.acc} !== {1'b1, want[j-1], want[j-1]}) begin
          n_bad++;
          $display("FAIL acc_chain%0d: got v=%0b out=%h acc=%h want v=1 out=%h acc=%h", j - 1,
                   bus8.out_valid, bus8.out, bus8.acc, want[j-1], want[j-1]);
        end
      end
      if (j < 3) begin
        logic [7:0] ra;
        ra = 8'($urandom_range(0, 255));
        e = exp8(ra, 8'h03, 3'd0, 1'b1);
        drive8(1, ra, 8'h03, 3'd0, 1);
      end else drive8(0, 0, 0, 0, 0);
    end
    n_cmp++;
    if (bus8.acc !== 8'h09 || macc != 9) begin
      n_bad++;
      $display("FAIL acc_final: got acc=%h model=%0d want 09", bus8.acc, macc);
    end
  endtask

  task automatic test_backpressure();
    logic [7:0] ra[3], rb[3];
    logic [2:0] rs[3];
    logic [19:0] e[3];
    logic [7:0] after[2];
    for (int i = 0; i < 3; i++) begin
      ra[i] = 8'($urandom_range(0, 255));
      rb[i] = 8'($urandom_range(0, 255));
      rs[i] = 3'($urandom_range(0, 6));
    end
    bus8.out_ready = 1'b0;
    e[0] = exp8(ra[0], rb[0], rs[0], 0);
    drive8(1, ra[0], rb[0], rs[0], 0);
    @(posedge clk);
    #1;
    n_cmp++;
    if (bus8.in_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL bp_second_accept: got in_ready=%b want 1", bus8.in_ready);
    end
    e[1] = exp8(ra[1], rb[1], rs[1], 0);
    drive8(1, ra[1], rb[1], rs[1], 0);
    @(posedge clk);
    #1;
    drive8(1, ra[2], rb[2], rs[2], 0);
    for (int k = 0; k < 3; k++) begin
      n_cmp++;
      if ({bus8.in_ready, bus8.out_valid, bus8.out, bus8.flags, bus8.acc} !== {2'b01, e[0][7:0], e[0][19:16], e[0][7:0]}) begin
        n_bad++;
        $display("FAIL bp_stall%0d: got rdy=%b v=%b out=%h f=%b acc=%h want rdy=0 v=1 out=%h f=%b", k,
                 bus8.in_ready, bus8.out_valid, bus8.out, bus8.flags, bus8.acc, e[0][7:0], e[0][19:16]);
      end
      @(posedge clk);
      #1;
    end
    bus8.out_ready = 1'b1;
    #1;
    n_cmp++;
    if (bus8.in_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL bp_release_ready: got in_ready=%b want 1", bus8.in_ready);
    end
    e[2] = exp8(ra[2], rb[2], rs[2], 0);
    after = '{e[1][7:0], e[2][7:0]};
    for (int j = 0; j < 3; j++) begin
      @(posedge clk);
      #1;
      if (j == 0) drive8(0, 0, 0, 0, 0);
      n_cmp++;
      if (j < 2 && {bus8.out_valid, bus8.out} !== {1'b1, after[j]}) begin
        n_bad++;
        $display("FAIL bp_drain%0d: got v=%b out=%h want v=1 out=%h", j, bus8.out_valid, bus8.out, after[j]);
      end else if (j == 2 && bus8.out_valid !== 1'b0) begin
        n_bad++;
        $display("FAIL bp_drain_end: got out_valid=%b want 0", bus8.out_valid);
      end
    end
  endtask

  task automatic test_random();
    logic took;
    took = 1'b1;
    q.delete();
    drive8(0, 0, 0, 0, 0);
    for (int c = 0; c < 420; c++) begin
      if (bus8.out_valid === 1'b1) begin
        n_cmp++;
        if (q.size() == 0) begin
          n_bad++;
          $display("FAIL rand_spurious cycle%0d: got out=%h want no result", c, bus8.out);
        end else if ({bus8.flags, bus8.out, bus8.acc} !== {q[0][19:16], q[0][7:0], q[0][7:0]}) begin
          n_bad++;
          $display("FAIL rand_result cycle%0d: got out=%h f=%b acc=%h want out=%h f=%b", c,
                   bus8.out, bus8.flags, bus8.acc, q[0][7:0], q[0][19:16]);
        end
      end
      if (c < 400) begin
        if (!bus8.in_valid || took)
          drive8($urandom_range(0, 3) != 0, 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
                 3'($urandom_range(0, 7)), $urandom_range(0, 3) == 0);
        bus8.out_ready = $urandom_range(0, 3) != 0;
      end else begin
        drive8(0, 0, 0, 0, 0);
        bus8.out_ready = 1'b1;
      end
      #1;
      took = bus8.in_valid && bus8.in_ready;
      if (bus8.out_valid && bus8.out_ready && q.size() > 0) void'(q.pop_front());
      if (took) q.push_back(exp8(bus8.a, bus8.b, bus8.sel, bus8.acc_en));
      @(posedge clk);
      #1;
    end
    n_cmp++;
    if (q.size() != 0 || bus8.out_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL rand_drain: got %0d results outstanding, out_valid=%b want 0 and 0", q.size(), bus8.out_valid);
    end
  endtask

  task automatic test_reset_mid();
    logic [7:0] ra, rb;
    logic [2:0] rs;
    logic [19:0] e;
    bus8.out_ready = 1'b1;
    drive8(1, 8'h11, 8'h22, 3'd0, 0);
    @(posedge clk);
    #1;
    drive8(1, 8'h40, 8'h0F, 3'd4, 0);
    @(posedge clk);
    #1;
    drive8(0, 0, 0, 0, 0);
    n_cmp++;
    if ({bus8.out_valid, bus8.acc} !== {1'b1, 8'h33}) begin
      n_bad++;
      $display("FAIL rst_mid_pre: got v=%b acc=%h want v=1 acc=33", bus8.out_valid, bus8.acc);
    end
    #2;
    rst = 1'b1;
    #1;
    n_cmp++;
    if ({bus8.out_valid, bus8.out, bus8.flags, bus8.acc} !== 21'b0) begin
      n_bad++;
      $display("FAIL rst_mid_async: got v=%b out=%h f=%b acc=%h want all 0", bus8.out_valid, bus8.out, bus8.flags, bus8.acc);
    end
    @(posedge clk);
    #2;
    rst = 1'b0;
    macc = 0;
    #1;
    n_cmp++;
    if (bus8.in_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL rst_mid_ready: got %b want 1", bus8.in_ready);
    end
    ra = 8'($urandom_range(0, 255));
    rb = 8'($urandom_range(0, 255));
    rs = 3'($urandom_range(0, 6));
    e = exp8(ra, rb, rs, 1'b1);
    drive8(1, ra, rb, rs, 1);
    @(posedge clk);
    #1;
    drive8(0, 0, 0, 0, 0);
    n_cmp++;
    if (bus8.out_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL rst_mid_latency1: got out_valid=%b want 0", bus8.out_valid);
    end
    @(posedge clk);
    #1;
    n_cmp++;
    if ({bus8.out_valid, bus8.out, bus8.flags} !== {1'b1, e[7:0], e[19:16]}) begin
      n_bad++;
      $display("FAIL rst_mid_result: got v=%b out=%h f=%b want v=1 out=%h f=%b", bus8.out_valid, bus8.out, bus8.flags, e[7:0], e[19:16]);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_width16();
    logic [15:0] wr[2];
    logic [3:0] wf[2];
    logic [19:0] e;
    wr = '{16'h0000, 16'hFF00};
    wf = '{4'b1010, 4'b0001};
    bus16.out_ready = 1'b1;
    bus16.a = 16'hFFFF;
    bus16.b = 16'h0001;
    bus16.sel = 3'd0;
    bus16.acc_en = 1'b0;
    bus16.in_valid = 1'b1;
    for (int j = 0; j < 4; j++) begin
      @(posedge clk);
      #1;
      if (j == 0) begin
        bus16.a = 16'h00FF;
        bus16.b = 16'($urandom_range(0, 65535));
        bus16.sel = 3'd5;
      end else bus16.in_valid = 1'b0;
      if (j == 1 || j == 2) begin
        n_cmp++;
        if ({bus16.out_valid, bus16.out, bus16.flags, bus16.acc} !== {1'b1, wr[j-1], wf[j-1], wr[j-1]}) begin
          n_bad++;
          $display("FAIL w16_op%0d: got v=%b out=%h f=%b acc=%h want v=1 out=%h f=%b", j - 1,
                   bus16.out_valid, bus16.out, bus16.flags, bus16.acc, wr[j-1], wf[j-1]);
        end
      end
    end
    e = model(16, 'hFFFF, 1, 0);
    n_cmp++;
    if (e !== {4'b1010, 16'h0000}) begin
      n_bad++;
      $display("FAIL w16_model_add: got %h want %h", e, {4'b1010, 16'h0000});
    end
  endtask

  initial begin
    test_reset();
    test_opcodes();
    test_flag_bounds();
    test_acc_chain();
    test_backpressure();
    test_random();
    test_reset_mid();
    test_width16();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
